// File: rtl/sniff_report_pkg.sv
// sniff_report_pkg: shared state enum and ASCII helpers for the
// sniffer UART line reporter.
package sniff_report_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } state_t;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] COLON = 8'h3A;

  localparam int LINE_LEN_BASE = 4;
  localparam int LINE_LEN_SEQ  = 7;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) return 8'h30 + {4'h0, nibble};
    return 8'h37 + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/sniff_uart_tx.sv
// sniff_uart_tx: 8N1 serializer, LSB first; done pulses during the
// last cycle of the stop bit so the next load follows without a gap.
module sniff_uart_tx
  import sniff_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  state_t      phase;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  assign done = (phase == STOP_BIT) && (cnt == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      unique case (phase)
        IDLE: begin
          if (load) begin
            shreg <= data;
            tx    <= 1'b0;
            cnt   <= RELOAD;
            phase <= START_BIT;
          end
        end
        START_BIT: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else begin
            tx      <= shreg[0];
            cnt     <= RELOAD;
            bit_idx <= '0;
            phase   <= DATA_BITS;
          end
        end
        DATA_BITS: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (bit_idx == 3'd7) begin
            tx    <= 1'b1;
            cnt   <= RELOAD;
            phase <= STOP_BIT;
          end else begin
            tx      <= shreg[1];
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
            cnt     <= RELOAD;
          end
        end
        STOP_BIT: begin
          if (cnt != 16'd0) cnt <= cnt - 16'd1;
          else phase <= IDLE;
        end
        default: phase <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sniff_uart_report.sv
// sniff_uart_report: buffers sniffer bytes and reports each as a hex
// text line over UART. SNIFF_REPORT_SEQ_EN prefixes a sequence number.
module sniff_uart_report
  import sniff_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic [7:0] data,
  output logic       start,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef SNIFF_REPORT_SEQ_EN
  localparam int EW       = 16;
  localparam int LINE_LEN = LINE_LEN_SEQ;
`else
  localparam int EW       = 8;
  localparam int LINE_LEN = LINE_LEN_BASE;
`endif
  localparam logic [2:0] LAST = 3'(LINE_LEN - 1);

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wp, rp, wp_n, rp_n;
  logic [EW-1:0] line, wr_entry;
  logic [2:0]    char_idx;
  logic [7:0]    char_q;
  state_t        state;
  logic          empty, full, full_n;
  logic          pop, push, load, done;

  assign empty  = (wp == rp);
  assign full   = (wp[AW] != rp[AW]) &&
                  (wp[AW-1:0] == rp[AW-1:0]);
  assign pop    = (state == IDLE) && !empty;
  assign push   = ready && (!full || pop);
  assign wp_n   = wp + {{AW{1'b0}}, push};
  assign rp_n   = rp + {{AW{1'b0}}, pop};
  assign full_n = (wp_n[AW] != rp_n[AW]) &&
                  (wp_n[AW-1:0] == rp_n[AW-1:0]);
  assign load   = (state == LOAD);
  assign busy   = (state != IDLE) | ~empty;

`ifdef SNIFF_REPORT_SEQ_EN
  logic [7:0] seq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) seq <= '0;
    else if (push) seq <= seq + 8'd1;
  end

  assign wr_entry = {seq, data};

  always_comb begin
    char_q = LF;
    unique case (char_idx)
      3'd0:    char_q = hex_ascii(line[15:12]);
      3'd1:    char_q = hex_ascii(line[11:8]);
      3'd2:    char_q = COLON;
      3'd3:    char_q = hex_ascii(line[7:4]);
      3'd4:    char_q = hex_ascii(line[3:0]);
      3'd5:    char_q = CR;
      default: char_q = LF;
    endcase
  end
`else
  assign wr_entry = data;

  always_comb begin
    char_q = LF;
    unique case (char_idx)
      3'd0:    char_q = hex_ascii(line[7:4]);
      3'd1:    char_q = hex_ascii(line[3:0]);
      3'd2:    char_q = CR;
      default: char_q = LF;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= wr_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      start    <= 1'b0;
      overflow <= 1'b0;
      state    <= IDLE;
      line     <= '0;
      char_idx <= '0;
    end else begin
      wp    <= wp_n;
      rp    <= rp_n;
      start <= !full_n;
      if (ready && !push) overflow <= 1'b1;
      unique case (state)
        IDLE: begin
          if (!empty) begin
            line     <= mem[rp[AW-1:0]];
            char_idx <= '0;
            state    <= LOAD;
          end
        end
        LOAD: state <= START_BIT;
        // serializer walks the bit phases; hold until its done pulse
        START_BIT: begin
          if (done) begin
            if (char_idx == LAST) begin
              state <= IDLE;
            end else begin
              char_idx <= char_idx + 3'd1;
              state    <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sniff_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk (clk),
    .rst (rst),
    .load(load),
    .data(char_q),
    .tx  (tx),
    .done(done)
  );

endmodule

// File: tb/tb_sniff_uart_report.sv
// tb_sniff_uart_report: scoreboard bench; a line-level model predicts
// FIFO occupancy and the expected UART characters.
module tb_sniff_uart_report;

  localparam int DEPTH = 4;
`ifdef SNIFF_REPORT_SEQ_EN
  localparam int CPB = 2;
  localparam int LL  = 7;
`else
  localparam int CPB = 4;
  localparam int LL  = 4;
`endif
  // cycles from a pop until the transmitter is idle again
  localparam int LINE_CYC = LL * (10 * CPB + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] data = 8'h00;
  logic       start, tx, busy, overflow;

  int total = 0;
  int bad   = 0;

  sniff_uart_report #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ready   (ready),
    .data    (data),
    .start   (start),
    .tx      (tx),
    .busy    (busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [7:0]  exp_q[$];
  logic [15:0] mq[$];
  int          m_wait = 0;
  bit          m_start = 0;
  bit          m_ovf = 0;
  logic [7:0]  m_seq = 8'h00;
  bit          chk_en = 0;
  string       hexd = "0123456789ABCDEF";

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endfunction

  function automatic void push_line(logic [15:0] e);
`ifdef SNIFF_REPORT_SEQ_EN
    exp_q.push_back(hexd[e[15:12]]);
    exp_q.push_back(hexd[e[11:8]]);
    exp_q.push_back(8'h3A);
`endif
    exp_q.push_back(hexd[e[7:4]]);
    exp_q.push_back(hexd[e[3:0]]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // behavioural model: occupancy queue plus line-duration timer
  always @(posedge clk) begin : model
    bit pm, am;
    if (!rst) begin
      pm = (m_wait == 0) && (mq.size() > 0);
      if (m_wait > 0) m_wait--;
      if (pm) begin
        push_line(mq.pop_front());
        m_wait = LINE_CYC;
      end
      am = ready && (mq.size() < DEPTH);
      if (am) begin
        mq.push_back({m_seq, data});
        m_seq++;
      end else if (ready) begin
        m_ovf = 1;
      end
      m_start = (mq.size() < DEPTH);
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("start", start, m_start);
      check("overflow", overflow, m_ovf);
      check("busy", busy, (m_wait > 0) || (mq.size() > 0));
    end
  end

  bit         mon_on = 0;
  int         mcnt = 0;
  logic [9:0] bv;
  bit         glitch = 0;

  // UART receiver: every cycle of every bit must hold the bit value
  always @(negedge clk) begin
    if (rst) begin
      mon_on = 0;
    end else begin
      if (!mon_on && tx === 1'b0) begin
        mon_on = 1;
        mcnt   = 0;
        glitch = 0;
      end
      if (mon_on) begin
        if (mcnt % CPB == 0) bv[mcnt / CPB] = tx;
        else if (tx !== bv[mcnt / CPB]) glitch = 1;
        mcnt++;
        if (mcnt == 10 * CPB) begin
          mon_on = 0;
          check("frame", {29'd0, glitch, bv[9], bv[0]}, 32'd2);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL char: got %02h want none", bv[8:1]);
          end else begin
            check("char", bv[8:1], exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    ready = 1'b0;
    m_wait = 0;
    mq.delete();
    exp_q.delete();
    m_start = 0;
    m_ovf   = 0;
    m_seq   = 8'h00;
    #1;
    check("rst_tx", tx, 1);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    tick();
    check("start_after_rst", start, 1);
  endtask

  task automatic drain(int lim);
    int n = 0;
    while ((exp_q.size() != 0 || mq.size() != 0 || m_wait != 0 ||
            busy !== 1'b0 || mon_on) && n < lim) begin
      tick();
      n++;
    end
    check("drain_timeout", n < lim, 1);
  endtask

  initial begin
    int n;
    int sent;
    #3;
    do_reset();
    chk_en = 1;

    // single byte, latency to the first start bit
    ready = 1'b1;
    data  = 8'h3A;
    tick();
    ready = 1'b0;
    check("lat_n", tx, 1);
    tick();
    check("lat_n1", tx, 1);
    tick();
    check("lat_n2", tx, 0);
    drain(2000);
    check("busy_idle", busy, 0);
    check("start_idle", start, 1);

    // boundary bytes
    ready = 1'b1;
    data  = 8'h00;
    tick();
    ready = 1'b0;
    repeat (100) tick();
    ready = 1'b1;
    data  = 8'hFF;
    tick();
    ready = 1'b0;
    drain(4000);

    // push on a full FIFO in the pop cycle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ready = 1'b1;
      data  = 8'h20 + 8'(i);
      tick();
    end
    ready = 1'b0;
    check("full_start", start, 0);
    n = 0;
    while (!(m_wait == 0 && mq.size() == DEPTH) && n < 2000) begin
      tick();
      n++;
    end
    check("pop_wait_timeout", n < 2000, 1);
    ready = 1'b1;
    data  = 8'h25;
    tick();
    ready = 1'b0;
    check("pop_push_ovf", overflow, 0);
    check("pop_push_start", start, 0);
    drain(8000);

    // six back-to-back pulses, last one dropped
    for (int i = 0; i < 6; i++) begin
      ready = 1'b1;
      data  = 8'h10 + 8'(i);
      tick();
    end
    ready = 1'b0;
    check("burst_ovf", overflow, 1);
    check("burst_start", start, 0);
    drain(8000);
    check("ovf_sticky", overflow, 1);

    // reset during the data bits of the second character
    ready = 1'b1;
    data  = 8'h5C;
    tick();
    ready = 1'b0;
    repeat (53) tick();
    check("rst_pending", exp_q.size(), 3);
    do_reset();
    repeat (300) tick();
    check("rst_quiet_busy", busy, 0);
    check("rst_quiet_ovf", overflow, 0);

`ifdef SNIFF_REPORT_SEQ_EN
    // sequence counter wrap across 257 accepted bytes
    do_reset();
    sent = 0;
    n = 0;
    while (sent < 257 && n < 60000) begin
      if (start) begin
        ready = 1'b1;
        data  = 8'hA5;
        sent++;
      end else begin
        ready = 1'b0;
      end
      tick();
      n++;
    end
    ready = 1'b0;
    check("seq_sent", sent, 257);
    drain(60000);
`else
    sent = 0;
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      ready = ($urandom_range(0, 99) < 6);
      data  = 8'($urandom);
      tick();
    end
    ready = 1'b0;
    drain(20000);
    check("final_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
